// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard, stall and flush controller for a 4-stage pipeline (IF, ID, EX, MWB).
// It keeps shadow copies of the register-use information held in the EX and
// MWB pipeline registers and, from those and the instruction currently in ID,
// produces:
//   - PC / IF/ID / EX/MWB register enables
//   - IF/ID flush and ID/EX bubble insertion
//   - EX-stage forwarding selects and ID-stage same-cycle write bypass
//   - a saturating stall-cycle counter and a sticky memory-timeout flag
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   id_*_in                 decode info of the instruction in IF/ID
//   ex_branch_taken_in      branch in EX resolved taken
//   mem_busy_in             data_memory still busy with the MWB access
//   pc_we_out               PC update enable
//   if_id_we_out            IF/ID register enable
//   if_id_flush_out         clear IF/ID valid
//   id_ex_bubble_out        load a NOP into ID/EX instead of the ID instruction
//   ex_mwb_we_out           EX/MWB register enable
//   fwd_a_sel_out/_b_       EX operand select: 00 ID/EX value, 01 MWB ALU result
//   id_bypass_rs/rt_out     ID register read takes MWB write data
//   stall_count_out         saturating count of cycles with pc_we_out = 0
//   timeout_err_out         sticky: MWB busy for MEM_TIMEOUT consecutive cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 1024,
  parameter int TMO_W       = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid_in,
  input  logic [4:0]             id_rs_in,
  input  logic [4:0]             id_rt_in,
  input  logic                   id_uses_rs_in,
  input  logic                   id_uses_rt_in,
  input  logic [4:0]             id_dest_in,
  input  logic                   id_writes_in,
  input  logic                   id_is_load_in,
  input  logic                   id_is_mem_in,
  input  logic                   ex_branch_taken_in,
  input  logic                   mem_busy_in,
  output logic                   pc_we_out,
  output logic                   if_id_we_out,
  output logic                   if_id_flush_out,
  output logic                   id_ex_bubble_out,
  output logic                   ex_mwb_we_out,
  output logic [1:0]             fwd_a_sel_out,
  output logic [1:0]             fwd_b_sel_out,
  output logic                   id_bypass_rs_out,
  output logic                   id_bypass_rt_out,
  output logic [STALL_CNT_W-1:0] stall_count_out,
  output logic                   timeout_err_out
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dest;
    logic       wr;
    logic       load;
    logic       mem;
  } ex_info_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wr;
    logic       load;
    logic       mem;
  } mwb_info_t;

  // State
  logic                   started_q;   // low from reset until the first edge after release
  ex_info_t               ex_q,        ex_d;
  mwb_info_t              mwb_q,       mwb_d;
  state_e                 state_q,     state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q,   tmo_cnt_d;
  logic                   tmo_err_q,   tmo_err_d;

  // Hazard terms
  logic freeze;
  logic load_use;
  logic mwb_fwd_ok;
  logic mwb_byp_ok;

  // Internal copies of the control outputs, also used by the next-state logic
  logic pc_we;
  logic if_id_we;
  logic if_id_flush;
  logic bubble;
  logic ex_mwb_we;

  // -------------------------------------------------------------------------
  // Hazard detection, forwarding and bypass
  // -------------------------------------------------------------------------
  always_comb begin
    // The MWB access holds the whole pipe while data_memory is still busy.
    freeze = mwb_q.valid & mwb_q.mem & mem_busy_in;

    // Register 0 is hard-wired, so a match against it is never a hazard.
    load_use = ex_q.valid & ex_q.load & (ex_q.dest != 5'd0) & id_valid_in &
               ((id_uses_rs_in & (id_rs_in == ex_q.dest)) |
                (id_uses_rt_in & (id_rt_in == ex_q.dest)));

    // Load data is not ready as an ALU result, so loads never forward into EX.
    mwb_fwd_ok = mwb_q.valid & mwb_q.wr & ~mwb_q.load & (mwb_q.dest != 5'd0);
    // The reg_file write happens in MWB, so ID bypass covers loads too.
    mwb_byp_ok = mwb_q.valid & mwb_q.wr & (mwb_q.dest != 5'd0);

    fwd_a_sel_out    = (ex_q.uses_rs & mwb_fwd_ok & (mwb_q.dest == ex_q.rs)) ? 2'b01 : 2'b00;
    fwd_b_sel_out    = (ex_q.uses_rt & mwb_fwd_ok & (mwb_q.dest == ex_q.rt)) ? 2'b01 : 2'b00;
    id_bypass_rs_out = mwb_byp_ok & (mwb_q.dest == id_rs_in);
    id_bypass_rt_out = mwb_byp_ok & (mwb_q.dest == id_rt_in);
  end

  // -------------------------------------------------------------------------
  // Pipeline enables, in priority order: freeze, branch, load-use, run
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b1;
    bubble      = 1'b0;
    ex_mwb_we   = 1'b0;

    if (started_q) begin
      if_id_flush = 1'b0;
      if (freeze) begin
        // Everything holds; a branch or load-use waits for the unfrozen cycle.
      end else if (ex_branch_taken_in) begin
        // The ID instruction is squashed, so any load-use on it is moot.
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        bubble      = 1'b1;
        ex_mwb_we   = 1'b1;
      end else if (load_use) begin
        // The bubble empties EX, so this stall clears itself next cycle.
        bubble    = 1'b1;
        ex_mwb_we = 1'b1;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        ex_mwb_we = 1'b1;
      end
    end
  end

  assign pc_we_out        = pc_we;
  assign if_id_we_out     = if_id_we;
  assign if_id_flush_out  = if_id_flush;
  assign id_ex_bubble_out = bubble;
  assign ex_mwb_we_out    = ex_mwb_we;
  assign stall_count_out  = stall_cnt_q;
  assign timeout_err_out  = tmo_err_q;

  // -------------------------------------------------------------------------
  // Next-state: shadows, FSM, counters
  // -------------------------------------------------------------------------
  always_comb begin
    ex_d  = ex_q;
    mwb_d = mwb_q;
    if (started_q && !freeze) begin
      mwb_d = '{valid: ex_q.valid, dest: ex_q.dest, wr: ex_q.wr,
                load: ex_q.load, mem: ex_q.mem};
      if (bubble) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid: id_valid_in, rs: id_rs_in, rt: id_rt_in,
                 uses_rs: id_uses_rs_in, uses_rt: id_uses_rt_in,
                 dest: id_dest_in, wr: id_writes_in,
                 load: id_is_load_in, mem: id_is_mem_in};
      end
    end

    state_d = freeze ? MEM_WAIT : RUN;

    // Counts consecutive frozen cycles; restarts at 1 on entry from RUN.
    tmo_cnt_d = '0;
    if (freeze) begin
      if (state_q == RUN) begin
        tmo_cnt_d = TMO_W'(1);
      end else if (tmo_cnt_q != TMO_LIMIT) begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_d = tmo_cnt_q;
      end
    end
    tmo_err_d = tmo_err_q | (freeze & (tmo_cnt_d == TMO_LIMIT));

    stall_cnt_d = stall_cnt_q;
    if (started_q && !pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      started_q   <= 1'b0;
      ex_q        <= '0;
      mwb_q       <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      started_q   <= 1'b1;
      ex_q        <= ex_d;
      mwb_q       <= mwb_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Table of per-cycle {inputs, expected outputs} records driven through the
// controller; expected outputs go through a scoreboard queue and are compared
// on the falling edge. Hand-written sequences cover stall-counter saturation
// and an asynchronous reset asserted mid-cycle during a memory wait.
// The DUT is built with a 4-bit stall counter and MEM_TIMEOUT = 4.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       idv;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
    logic       mem;
    logic       br;
    logic       busy;
  } in_t;

  typedef struct packed {
    logic       pc_we;
    logic       if_id_we;
    logic       flush;
    logic       bubble;
    logic       ex_mwb_we;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       byp_rs;
    logic       byp_rt;
    logic [3:0] stall;
    logic       tmo;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       id_valid_in;
  logic [4:0] id_rs_in;
  logic [4:0] id_rt_in;
  logic       id_uses_rs_in;
  logic       id_uses_rt_in;
  logic [4:0] id_dest_in;
  logic       id_writes_in;
  logic       id_is_load_in;
  logic       id_is_mem_in;
  logic       ex_branch_taken_in;
  logic       mem_busy_in;
  logic       pc_we_out;
  logic       if_id_we_out;
  logic       if_id_flush_out;
  logic       id_ex_bubble_out;
  logic       ex_mwb_we_out;
  logic [1:0] fwd_a_sel_out;
  logic [1:0] fwd_b_sel_out;
  logic       id_bypass_rs_out;
  logic       id_bypass_rt_out;
  logic [3:0] stall_count_out;
  logic       timeout_err_out;

  logic [15:0] got;
  assign got = {pc_we_out, if_id_we_out, if_id_flush_out, id_ex_bubble_out,
                ex_mwb_we_out, fwd_a_sel_out, fwd_b_sel_out, id_bypass_rs_out,
                id_bypass_rt_out, stall_count_out, timeout_err_out};

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];
  vec_t vecs[33];

  pipeline_hazard_ctrl #(
    .STALL_CNT_W(4),
    .MEM_TIMEOUT(4),
    .TMO_W      (3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .id_valid_in       (id_valid_in),
    .id_rs_in          (id_rs_in),
    .id_rt_in          (id_rt_in),
    .id_uses_rs_in     (id_uses_rs_in),
    .id_uses_rt_in     (id_uses_rt_in),
    .id_dest_in        (id_dest_in),
    .id_writes_in      (id_writes_in),
    .id_is_load_in     (id_is_load_in),
    .id_is_mem_in      (id_is_mem_in),
    .ex_branch_taken_in(ex_branch_taken_in),
    .mem_busy_in       (mem_busy_in),
    .pc_we_out         (pc_we_out),
    .if_id_we_out      (if_id_we_out),
    .if_id_flush_out   (if_id_flush_out),
    .id_ex_bubble_out  (id_ex_bubble_out),
    .ex_mwb_we_out     (ex_mwb_we_out),
    .fwd_a_sel_out     (fwd_a_sel_out),
    .fwd_b_sel_out     (fwd_b_sel_out),
    .id_bypass_rs_out  (id_bypass_rs_out),
    .id_bypass_rt_out  (id_bypass_rt_out),
    .stall_count_out   (stall_count_out),
    .timeout_err_out   (timeout_err_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Argument order: idv, rs, rt, uses_rs, uses_rt, dest, writes, load, mem, branch, busy
  function automatic in_t ins(input logic idv, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] dest,
                              input logic wr, input logic ld, input logic mem,
                              input logic br, input logic busy);
    in_t r;
    r = '{idv: idv, rs: rs, rt: rt, urs: urs, urt: urt, dest: dest,
          wr: wr, ld: ld, mem: mem, br: br, busy: busy};
    return r;
  endfunction

  // Argument order: pc_we, if_id_we, flush, bubble, ex_mwb_we, fwd_a, fwd_b,
  // bypass_rs, bypass_rt, stall_count, timeout_err
  function automatic exp_t ev(input logic pc, input logic ifw, input logic fl,
                              input logic bub, input logic exw, input logic [1:0] fa,
                              input logic [1:0] fb, input logic bs, input logic bt,
                              input logic [3:0] st, input logic tmo);
    exp_t r;
    r = '{pc_we: pc, if_id_we: ifw, flush: fl, bubble: bub, ex_mwb_we: exw,
          fwd_a: fa, fwd_b: fb, byp_rs: bs, byp_rt: bt, stall: st, tmo: tmo};
    return r;
  endfunction

  function automatic exp_t nrm(input logic [3:0] st, input logic tmo);
    return ev(1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, st, tmo);
  endfunction

  function automatic exp_t frz(input logic [3:0] st, input logic tmo);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, st, tmo);
  endfunction

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] want);
    n_total++;
    if (actual === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (pc,ifw,fl,bub,exw,fa[2],fb[2],brs,brt,stall[4],tmo)",
               name, actual, want);
    end
  endtask

  task automatic drive(input in_t i);
    id_valid_in        = i.idv;
    id_rs_in           = i.rs;
    id_rt_in           = i.rt;
    id_uses_rs_in      = i.urs;
    id_uses_rt_in      = i.urt;
    id_dest_in         = i.dest;
    id_writes_in       = i.wr;
    id_is_load_in      = i.ld;
    id_is_mem_in       = i.mem;
    ex_branch_taken_in = i.br;
    mem_busy_in        = i.busy;
  endtask

  // Drive one cycle of stimulus just after a rising edge, compare on the
  // falling edge, then step to just after the next rising edge.
  task automatic step(input in_t i, input exp_t e, input string name);
    exp_t want;
    drive(i);
    exp_q.push_back(e);
    @(negedge clock);
    want = exp_q.pop_front();
    check(name, got, want);
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_t  idle, busy, br_busy, br_only, w_ld5, w_use5, w_sw;
    exp_t rst_exp;
    logic [3:0] st;

    idle    = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy    = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    br_busy = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    br_only = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    w_ld5   = ins(1, 6, 0, 1, 0, 5, 1, 1, 1, 0, 0);   // lw $5, 0($6)
    w_use5  = ins(1, 1, 5, 1, 1, 7, 1, 0, 0, 0, 0);   // add $7, $1, $5
    w_sw    = ins(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);   // sw $2, 0($1)
    rst_exp = ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0);

    // First cycle after reset release: outputs still at reset values.
    vecs[0]  = '{idle, rst_exp};
    // add $3 then add $4,$3,$1: forward into EX operand A, no stall.
    vecs[1]  = '{ins(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0), nrm(0, 0)};
    vecs[2]  = '{ins(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0), nrm(0, 0)};
    vecs[3]  = '{idle, ev(1, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 4'd0, 0)};
    // lw $5 then consumer on rt: one stall cycle, then ID bypass on rt.
    vecs[4]  = '{w_ld5, nrm(0, 0)};
    vecs[5]  = '{w_use5, ev(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 4'd0, 0)};
    vecs[6]  = '{w_use5, ev(1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 4'd1, 0)};
    vecs[7]  = '{idle, nrm(1, 0)};
    // Register 0: lw $0 / add $0 followed by readers of $0 never hit.
    vecs[8]  = '{ins(1, 6, 0, 1, 0, 0, 1, 1, 1, 0, 0), nrm(1, 0)};
    vecs[9]  = '{ins(1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0), nrm(1, 0)};
    vecs[10] = '{ins(1, 0, 9, 1, 1, 0, 1, 0, 0, 0, 0), nrm(1, 0)};
    vecs[11] = '{ins(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0), nrm(1, 0)};
    vecs[12] = '{idle, nrm(1, 0)};
    // Load-use and taken branch in the same cycle: branch wins.
    vecs[13] = '{w_ld5, nrm(1, 0)};
    vecs[14] = '{ins(1, 5, 1, 1, 1, 7, 1, 0, 0, 1, 0), ev(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0, 4'd1, 0)};
    vecs[15] = '{idle, nrm(1, 0)};
    // Store in MWB with memory busy for 3 cycles: full freeze, stall += 3.
    vecs[16] = '{w_sw, nrm(1, 0)};
    vecs[17] = '{ins(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0), nrm(1, 0)};
    vecs[18] = '{busy, frz(1, 0)};
    vecs[19] = '{busy, frz(2, 0)};
    vecs[20] = '{busy, frz(3, 0)};
    vecs[21] = '{idle, nrm(4, 0)};
    // Load in MWB busy 5 cycles with a taken branch held in EX: timeout on
    // the 4th frozen edge, then the branch flushes on the first free cycle.
    vecs[22] = '{ins(1, 1, 0, 1, 0, 13, 1, 1, 1, 0, 0), nrm(4, 0)};
    vecs[23] = '{idle, nrm(4, 0)};
    vecs[24] = '{br_busy, frz(4, 0)};
    vecs[25] = '{br_busy, frz(5, 0)};
    vecs[26] = '{br_busy, frz(6, 0)};
    vecs[27] = '{br_busy, frz(7, 0)};
    vecs[28] = '{br_busy, frz(8, 1)};
    vecs[29] = '{br_only, ev(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0, 4'd9, 1)};
    vecs[30] = '{idle, nrm(9, 1)};
    // Put another store into MWB for the saturation sequence.
    vecs[31] = '{w_sw, nrm(9, 1)};
    vecs[32] = '{idle, nrm(9, 1)};

    reset = 1'b1;
    drive(idle);
    @(negedge clock);
    check("reset_values", got, rst_exp);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 33; k++) begin
      step(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));
    end

    // Long freeze: stall counter climbs from 9 and saturates at 15.
    st = 4'd9;
    for (int n = 0; n < 8; n++) begin
      step(busy, frz(st, 1), $sformatf("sat%0d", n));
      st = (st == 4'hf) ? 4'hf : st + 4'd1;
    end

    // Reset asserted between edges while frozen: outputs drop immediately.
    drive(busy);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_wait", got, rst_exp);
    @(posedge clock);
    #1;
    reset = 1'b0;
    // Busy stays high, but MWB shadow is empty so the pipe runs after one cycle.
    step(busy, rst_exp, "post_reset0");
    step(busy, nrm(0, 0), "post_reset1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
